note_lane_renderer: RTL

//  Pixel generator between the note-sequence stage and vga_adapter (160x120, 3-bit colour).
//  On each start pulse it snapshots the red/yellow note bitmaps, then repaints every

---
 rtl/note_lane_renderer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/note_lane_renderer.sv
// Repaints the note lane as a row of SQxSQ squares, one pixel per clock, for vga_adapter.
// Bitmaps are snapshotted on start so mid-frame changes upstream cannot tear the frame.
module note_lane_renderer #(
    parameter int unsigned N_SLOTS = 10,
    parameter int unsigned SQ      = 4,
    parameter int unsigned X0      = 20,
    parameter int unsigned Y0      = 56,
    parameter int unsigned PITCH   = 12
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [N_SLOTS-1:0] red_seq,
    input  logic [N_SLOTS-1:0] yellow_seq,
    output logic [7:0]         x,
    output logic [6:0]         y,
    output logic [2:0]         colour,
    output logic               plot,
    output logic               busy,
    output logic               done
);

    localparam int unsigned SW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam int unsigned OW = (SQ > 1) ? $clog2(SQ) : 1;

    if ((X0 + (N_SLOTS - 1) * PITCH + SQ - 1 > 159) || (Y0 + SQ - 1 > 119) ||
        (SQ < 1) || (SQ > 8) || (PITCH < SQ)) begin : g_param_err
        $error("note_lane_renderer: lane geometry does not fit the 160x120 frame");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        FIN  = 2'd2
    } state_e;

    state_e             state_q;
    logic [N_SLOTS-1:0] red_q;
    logic [N_SLOTS-1:0] yel_q;
    logic [SW-1:0]      slot_q;
    logic [OW-1:0]      xoff_q;
    logic [OW-1:0]      yoff_q;
    logic [7:0]         x_q;
    logic [6:0]         y_q;
    logic [2:0]         colour_q;
    logic               plot_q;
    logic               busy_q;
    logic               done_q;

    logic [7:0] px_c;
    logic [6:0] py_c;
    logic [2:0] pcol_c;
    logic       last_x_c;
    logic       last_y_c;
    logic       last_slot_c;

    // Pixel for the current counter position; red wins over yellow, empty slots erase.
    always_comb begin
        px_c        = 8'(X0) + 8'(slot_q) * 8'(PITCH) + 8'(xoff_q);
        py_c        = 7'(Y0) + 7'(yoff_q);
        pcol_c      = 3'b000;
        if (red_q[slot_q]) begin
            pcol_c = 3'b100;
        end else if (yel_q[slot_q]) begin
            pcol_c = 3'b110;
        end
        last_x_c    = (xoff_q == OW'(SQ - 1));
        last_y_c    = (yoff_q == OW'(SQ - 1));
        last_slot_c = (slot_q == SW'(N_SLOTS - 1));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            red_q    <= '0;
            yel_q    <= '0;
            slot_q   <= '0;
            xoff_q   <= '0;
            yoff_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            plot_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        red_q   <= red_seq;
                        yel_q   <= yellow_seq;
                        slot_q  <= '0;
                        xoff_q  <= '0;
                        yoff_q  <= '0;
                        state_q <= DRAW;
                    end
                end
                DRAW: begin
                    x_q      <= px_c;
                    y_q      <= py_c;
                    colour_q <= pcol_c;
                    plot_q   <= 1'b1;
                    busy_q   <= 1'b1;
                    // xoff innermost, then yoff, then slot
                    if (!last_x_c) begin
                        xoff_q <= xoff_q + OW'(1);
                    end else begin
                        xoff_q <= '0;
                        if (!last_y_c) begin
                            yoff_q <= yoff_q + OW'(1);
                        end else begin
                            yoff_q <= '0;
                            if (last_slot_c) begin
                                state_q <= FIN;
                            end else begin
                                slot_q <= slot_q + SW'(1);
                            end
                        end
                    end
                end
                FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
